sd_io_arbiter: RTL and testbench
================================

Name: sd_io_arbiter

Overview:
- Shares the single IO-controller sector channel (lba/rd/wr/ack plus byte strobes) between NUM_REQ sd_card emulation instances, e.g. several virtual drive images.
- Round-robin arbiter with one outstanding transfer at a time.
- Grant is held from request issue until the IO controller's ack falls.
- Sits between the sd_card instances and user_io.

Parameters:
- NUM_REQ, 2, number of sd_card requesters (legal 1..4).
- TIMEOUT_CYCLES, 16777216, clk cycles without io_ack rise before abort (SD_ARB_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_lba  in  32*NUM_REQ  per-requester sector LBA, requester i at bits [32*i+31:32*i]
- req_rd  in  NUM_REQ  per-requester read request (level)
- req_wr  in  NUM_REQ  per-requester write request (level)
- req_ack  out  NUM_REQ  io_ack routed to granted requester
- req_din  out  8  io_din broadcast to all requesters
- req_din_strobe  out  NUM_REQ  io_din_strobe routed to granted requester
- req_dout  in  8*NUM_REQ  per-requester outgoing sector byte
- req_dout_strobe  out  NUM_REQ  io_dout_strobe routed to granted requester
- io_lba  out  32  LBA to IO controller
- io_rd  out  1  sector read request to IO controller
- io_wr  out  1  sector write request to IO controller
- io_sel  out  2  index of granted requester (drive number)
- io_ack  in  1  IO controller acknowledge (asynchronous)
- io_din  in  8  sector byte from IO controller
- io_din_strobe  in  1  byte strobe from IO controller
- io_dout  out  8  req_dout of granted requester
- io_dout_strobe  in  1  byte strobe from IO controller
- busy  out  1  arbiter not in IDLE
- err  out  1  one-cycle abort pulse (SD_ARB_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, grant none; io_rd, io_wr, busy, err = 0; io_lba = 0; io_sel = 0; req_ack, req_*_strobe = 0.
- Synchronisation:
  - io_ack passes a 2-flop synchroniser (ack_s) for FSM use.
  - req_rd and req_wr pass a 2-flop synchroniser each; requesters set them asynchronously.
- Combinational routing, gated by the registered grant:
  - req_ack[i] = io_ack & grant[i]
  - req_din_strobe[i] = io_din_strobe & grant[i]
  - req_dout_strobe[i] = io_dout_strobe & grant[i]
  - io_dout = req_dout of io_sel
  - With no grant, all routed outputs are 0.
- FSM:
  - IDLE: if any synced req_rd|req_wr, pick the first requester at or after the rr pointer (wrap modulo NUM_REQ) and go to ISSUE next cycle. In that cycle latch grant, io_sel, io_lba from that requester, and op.
    - op = rd if req_rd is set; otherwise wr.
    - rd has priority over wr when a requester asserts both; the wr is served on a later arbitration.
  - ISSUE: drive io_rd or io_wr = 1. On ack_s = 1, deassert io_rd/io_wr and go to XFER.
  - XFER: routing active. On ack_s = 0 (ack fell), go to DONE.
  - DONE (1 cycle): clear grant; rr pointer = granted index + 1 mod NUM_REQ; go to IDLE.
- Latency: IDLE to io_rd/io_wr high = 1 clk after the synced request is seen, i.e. 3 clk from raw request.
- io_lba and io_sel are stable from ISSUE through DONE. Requester LBA changes after latch are ignored.
- A request withdrawn before sampling in IDLE is not served. A request withdrawn after grant does not abort the transfer.
- The served requester's own request level is cleared by req_ack; the arbiter does not re-serve it unless the synced level is still high in IDLE after DONE.
- busy = (state != IDLE).
- Reset mid-transfer: immediate return to reset values; the upstream transfer is abandoned.

Optional Feature:
- SD_ARB_TIMEOUT_EN defined:
  - A 24-bit counter runs in ISSUE and XFER, cleared on each state entry.
  - On reaching TIMEOUT_CYCLES-1: force DONE, pulse err for 1 clk, deassert io_rd/io_wr, advance the rr pointer.
- Undefined: no counter; err tied 0; the FSM waits indefinitely.

Test Plan:
- Requester 0 raises req_rd with LBA 0x00000123; IO controller acks 5 clk after io_rd, holds ack 600 clk, strobes 512 din bytes -> io_rd high 3 clk after request, io_lba = 0x123, io_sel = 0, req_ack[0] high 600 clk, req_din_strobe[0] = 512 pulses, req_din_strobe[1] = 0.
- Req 0 and req 1 assert req_rd in the same cycle from reset -> req 0 served first, then req 1; io_sel sequence 0,1; next simultaneous pair served 1,0? No: pointer after req 1 is 0 -> served 0,1 again, alternating fairly.
- Req 1 asserts both req_rd and req_wr with LBA 0x40 -> first transfer io_rd with io_lba 0x40; after DONE, io_wr with io_lba 0x40.
- Req 0 write transfer; 512 io_dout_strobe pulses, req_dout[0] = 0xA5, req_dout[1] = 0x3C -> io_dout = 0xA5 throughout; req_dout_strobe[1] never pulses.
- Assert reset_n = 0 during XFER -> io_rd, io_wr, busy, all req_ack = 0 immediately; after release a pending request is re-arbitrated from pointer 0.
- SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 100, no io_ack -> io_rd drops and err pulses exactly 1 clk at cycle 100 of ISSUE; busy low 1 clk later.

Source files
------------

// File: rtl/sd_io_arbiter.sv
// rtl/sd_io_arbiter.sv - round-robin arbiter sharing one IO-controller sector channel between NUM_REQ sd_card requesters.
// Optional abort timer compiled in with `define SD_ARB_TIMEOUT_EN.
module sd_io_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [32*NUM_REQ-1:0]  req_lba,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [NUM_REQ-1:0]     req_wr,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [7:0]             req_din,
  output logic [NUM_REQ-1:0]     req_din_strobe,
  input  logic [8*NUM_REQ-1:0]   req_dout,
  output logic [NUM_REQ-1:0]     req_dout_strobe,
  output logic [31:0]            io_lba,
  output logic                   io_rd,
  output logic                   io_wr,
  output logic [1:0]             io_sel,
  input  logic                   io_ack,
  input  logic [7:0]             io_din,
  input  logic                   io_din_strobe,
  output logic [7:0]             io_dout,
  input  logic                   io_dout_strobe,
  output logic                   busy,
  output logic                   err
);

  if (NUM_REQ < 1 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 16777216) begin : g_bad_param
    $error("sd_io_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t               state_q, state_d;
  logic                 ack_m_q, ack_s_q;
  logic [NUM_REQ-1:0]   rd_m_q, rd_s_q, wr_m_q, wr_s_q;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           rr_q, rr_d;
  logic [31:0]          lba_q, lba_d;
  logic                 op_wr_q, op_wr_d;
  logic                 timeout;
  logic                 pick_valid;
  logic [1:0]           pick_idx;
  int                   cand;

  // ack and request levels come from other clock domains
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_m_q <= 1'b0;
      ack_s_q <= 1'b0;
      rd_m_q  <= '0;
      rd_s_q  <= '0;
      wr_m_q  <= '0;
      wr_s_q  <= '0;
    end else begin
      ack_m_q <= io_ack;
      ack_s_q <= ack_m_q;
      rd_m_q  <= req_rd;
      rd_s_q  <= rd_m_q;
      wr_m_q  <= req_wr;
      wr_s_q  <= wr_m_q;
    end
  end

  // Scan from the farthest offset down so the nearest requester at/after rr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    cand       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_q) + k) % NUM_REQ;
      if (rd_s_q[cand] || wr_s_q[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = 2'(cand);
      end
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign timeout = ((state_q == ISSUE) || (state_q == XFER)) &&
                   (cnt_q == 24'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = 24'd0;
    err_d = timeout;
    if (((state_q == ISSUE) || (state_q == XFER)) && (state_d == state_q)) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 24'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    lba_d   = lba_q;
    op_wr_d = op_wr_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          grant_d = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          lba_d   = req_lba[32*int'(pick_idx) +: 32];
          op_wr_d = ~rd_s_q[pick_idx];
        end
      end
      ISSUE: begin
        if (timeout) begin
          state_d = DONE;
        end else if (ack_s_q) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (timeout || !ack_s_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        rr_d    = (int'(sel_q) == NUM_REQ - 1) ? 2'd0 : sel_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 2'd0;
      rr_q    <= 2'd0;
      lba_q   <= 32'd0;
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      op_wr_q <= op_wr_d;
    end
  end

  assign io_rd           = (state_q == ISSUE) && !op_wr_q;
  assign io_wr           = (state_q == ISSUE) &&  op_wr_q;
  assign io_lba          = lba_q;
  assign io_sel          = sel_q;
  assign busy            = (state_q != IDLE);
  assign req_ack         = {NUM_REQ{io_ack}} & grant_q;
  assign req_din_strobe  = {NUM_REQ{io_din_strobe}} & grant_q;
  assign req_dout_strobe = {NUM_REQ{io_dout_strobe}} & grant_q;
  assign req_din         = io_din;
  assign io_dout         = (|grant_q) ? req_dout[8*int'(sel_q) +: 8] : 8'h00;

endmodule

// File: tb/tb_sd_io_arbiter.sv
// tb/tb_sd_io_arbiter.sv - randomized self-checking bench for sd_io_arbiter (default build).
module tb_sd_io_arbiter;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [32*NR-1:0]  req_lba;
  logic [NR-1:0]     req_rd, req_wr;
  logic [NR-1:0]     req_ack;
  logic [7:0]        req_din;
  logic [NR-1:0]     req_din_strobe;
  logic [8*NR-1:0]   req_dout;
  logic [NR-1:0]     req_dout_strobe;
  logic [31:0]       io_lba;
  logic              io_rd, io_wr;
  logic [1:0]        io_sel;
  logic              io_ack;
  logic [7:0]        io_din;
  logic              io_din_strobe;
  logic [7:0]        io_dout;
  logic              io_dout_strobe;
  logic              busy, err;

  int n_chk = 0;
  int n_err = 0;
  int ptr_m = 0;

  sd_io_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
    .req_ack(req_ack), .req_din(req_din), .req_din_strobe(req_din_strobe),
    .req_dout(req_dout), .req_dout_strobe(req_dout_strobe),
    .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr), .io_sel(io_sel),
    .io_ack(io_ack), .io_din(io_din), .io_din_strobe(io_din_strobe),
    .io_dout(io_dout), .io_dout_strobe(io_dout_strobe),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int exp_pick();
    for (int k = 0; k < NR; k++) begin
      if (req_rd[(ptr_m + k) % NR] || req_wr[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    end
    return -1;
  endfunction

  // Plays one IO-controller transfer and the granted requester's ack response.
  task automatic serve_one(input int ack_dly, input int nstb, input int ack_len,
                           input bit scramble, output int lat);
    int e, n_own, n_oth, n_ack, n_bad, w;
    bit is_rd, stb;
    logic [31:0] lba_e;
    logic [7:0]  dout_e;
    logic [NR-1:0] mask;
    e = exp_pick();
    lat = 0;
    if (e < 0) begin
      check("model_pending", 0, 1);
      return;
    end
    is_rd  = req_rd[e];
    lba_e  = req_lba[32*e +: 32];
    dout_e = req_dout[8*e +: 8];
    mask   = NR'(1) << e;
    while (!(io_rd || io_wr) && lat < 40) begin
      tick();
      lat++;
    end
    check("issue_seen", 64'(io_rd | io_wr), 1);
    check("io_sel", 64'(io_sel), 64'(e));
    check("io_lba", 64'(io_lba), 64'(lba_e));
    check("io_op", 64'({io_rd, io_wr}), is_rd ? 64'd2 : 64'd1);
    check("busy_issue", 64'(busy), 1);
    repeat (ack_dly) tick();
    check("op_wait_ack", 64'({io_rd, io_wr}), is_rd ? 64'd2 : 64'd1);
    io_ack = 1'b1;
    #1;
    check("req_ack_rise", 64'(req_ack), 64'(mask));
    if (is_rd) req_rd[e] = 1'b0;
    else       req_wr[e] = 1'b0;
    if (scramble) req_lba[32*e +: 32] = $urandom;
    n_own = 0; n_oth = 0; n_ack = 0; n_bad = 0;
    for (int c = 0; c < ack_len; c++) begin
      tick();
      if (c == 1) check("op_hold", 64'({io_rd, io_wr}), is_rd ? 64'd2 : 64'd1);
      if (c == 3) check("op_drop", 64'({io_rd, io_wr}), 0);
      stb = (c >= 4) && (c < 4 + nstb);
      io_din = 8'($urandom);
      if (is_rd) io_din_strobe  = stb;
      else       io_dout_strobe = stb;
      #1;
      if ((is_rd ? req_din_strobe : req_dout_strobe) == mask) n_own++;
      if (((req_din_strobe | req_dout_strobe) & ~mask) != 0) n_oth++;
      if (req_ack == mask) n_ack++;
      if (req_din != io_din) n_bad++;
      if (!is_rd && io_dout != dout_e) n_bad++;
      if (io_lba != lba_e || int'(io_sel) != e) n_bad++;
    end
    io_ack = 1'b0;
    io_din_strobe = 1'b0;
    io_dout_strobe = 1'b0;
    #1;
    check("req_ack_fall", 64'(req_ack), 0);
    check("own_strobes", 64'(n_own), 64'(nstb));
    check("other_strobes", 64'(n_oth), 0);
    check("ack_cycles", 64'(n_ack), 64'(ack_len));
    check("data_route", 64'(n_bad), 0);
    w = 0;
    while (busy && w < 20) begin
      tick();
      w++;
    end
    check("back_idle", 64'(busy), 0);
    check("err_low", 64'(err), 0);
    ptr_m = (e + 1) % NR;
  endtask

  initial begin
    int lat, npend, e;
    reset_n = 1'b0;
    req_lba = '0; req_rd = '0; req_wr = '0; req_dout = '0;
    io_ack = 1'b0; io_din = '0; io_din_strobe = 1'b0; io_dout_strobe = 1'b0;
    repeat (3) tick();
    check("rst_outs", 64'({io_rd, io_wr, busy, err, io_sel, req_ack}), 0);
    check("rst_lba", 64'(io_lba), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", 64'(busy), 0);

    // Simultaneous pair twice: fair order 0,1 then 0,1 again.
    for (int r = 0; r < 2; r++) begin
      req_lba = {32'h0000_1111, 32'h0000_2222};
      req_rd = 2'b11;
      serve_one(2, 3, 10, 1'b0, lat);
      check("pair_latency", 64'(lat), 3);
      serve_one(2, 3, 10, 1'b0, lat);
    end

    // Requester 0 read, ack 5 clk after io_rd, 600 clk ack, 512 bytes.
    req_lba[31:0] = 32'h0000_0123;
    req_rd[0] = 1'b1;
    serve_one(5, 512, 600, 1'b0, lat);
    check("rd_latency", 64'(lat), 3);

    // Requester 1 read+write: read first, write on a later arbitration.
    req_lba[63:32] = 32'h0000_0040;
    req_rd[1] = 1'b1;
    req_wr[1] = 1'b1;
    serve_one(3, 4, 12, 1'b0, lat);
    serve_one(3, 4, 12, 1'b0, lat);

    // Requester 0 write: io_dout carries 0xA5 throughout.
    req_dout = {8'h3C, 8'hA5};
    req_wr[0] = 1'b1;
    serve_one(2, 512, 520, 1'b0, lat);

    // Reset during XFER, then re-arbitration restarts at requester 0.
    req_rd = 2'b11;
    e = exp_pick();
    lat = 0;
    while (!io_rd && lat < 40) begin
      tick();
      lat++;
    end
    check("rst_pre_sel", 64'(io_sel), 64'(e));
    io_ack = 1'b1;
    repeat (4) tick();
    check("rst_pre_busy", 64'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outs", 64'({io_rd, io_wr, busy, req_ack, io_sel}), 0);
    check("rst_mid_lba", 64'(io_lba), 0);
    io_ack = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    ptr_m = 0;
    serve_one(2, 2, 8, 1'b0, lat);
    serve_one(2, 2, 8, 1'b0, lat);

    // Randomized rounds launched from idle.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NR; i++) begin
        req_rd[i] = 1'($urandom);
        req_wr[i] = 1'($urandom);
        req_lba[32*i +: 32] = $urandom;
        req_dout[8*i +: 8] = 8'($urandom);
      end
      if ((req_rd | req_wr) == 0) req_rd[$urandom_range(NR-1, 0)] = 1'b1;
      npend = $countones(req_rd) + $countones(req_wr);
      for (int t = 0; t < npend; t++) begin
        int ns;
        ns = $urandom_range(8, 1);
        serve_one($urandom_range(6, 1), ns, ns + $urandom_range(10, 6), 1'b1, lat);
        if (t == 0) check("rnd_latency", 64'(lat), 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
